// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver; mid-bit start qualification, LSB-first data,
// stop-bit check, right-justified byte with a one-cycle done strobe.
module uart_rx_core #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_in,
    input  logic              rx_in,
    input  logic [3:0]        n_bits,
    output logic [DATA_W-1:0] data_out,
    output logic              rx_done,
    output logic              frame_err,
    output logic              busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [3:0]             nb_q, nb_d;
    logic [DATA_W-1:0]      shreg_q, shreg_d;
    logic [DATA_W-1:0]      data_out_q, data_out_d;
    logic                   rx_done_q, rx_done_d;
    logic                   frame_err_q, frame_err_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxs;

    assign rxs = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], rx_in};
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        nb_d        = nb_q;
        shreg_d     = shreg_q;
        data_out_d  = data_out_q;
        frame_err_d = frame_err_q;
        rx_done_d   = 1'b0;
        case (state_q)
            IDLE: if (!rxs) begin
                state_d    = START;
                tick_cnt_d = '0;
                nb_d       = (n_bits >= 4'd5 && n_bits <= 4'(DATA_W)) ? n_bits : 4'(DATA_W);
            end
            START: if (tick_in) begin
                if (tick_cnt_q == HALF) begin
                    state_d    = rxs ? IDLE : DATA;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            DATA: if (tick_in) begin
                if (tick_cnt_q == LAST) begin
                    shreg_d    = {rxs, shreg_q[DATA_W-1:1]};
                    tick_cnt_d = '0;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    state_d    = (bit_cnt_q == nb_q - 4'd1) ? STOP : DATA;
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            STOP: if (tick_in) begin
                if (tick_cnt_q == LAST) begin
                    // shifting in at the MSB leaves a short frame left-justified
                    data_out_d  = shreg_q >> (4'(DATA_W) - nb_q);
                    frame_err_d = ~rxs;
                    rx_done_d   = 1'b1;
                    tick_cnt_d  = '0;
                    state_d     = IDLE;
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            nb_q        <= '0;
            shreg_q     <= '0;
            data_out_q  <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            sync_q      <= '1;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            nb_q        <= nb_d;
            shreg_q     <= shreg_d;
            data_out_q  <= data_out_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            sync_q      <= sync_d;
        end
    end

    assign data_out  = data_out_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);
endmodule
